perfcounter_reader: RTL
=======================

# perfcounter_reader

Readout engine for one performance-counter set (one domain/space pair). On a host request it snapshots the six 64-bit counters in one cycle, streams them as thirteen 32-bit words (a header, then low/high halves) over a valid/ready stream, and optionally pulses `reset_count` back to the counter block so the next interval starts from zero. It sits between the counter bank and the host-side debug/register transport.

## Interface
- `HEADER_MAGIC`, 8'hA5: top byte of the header word.
- `CLK` input 1: single clock. One clock; reset is synchronous and active-high.
- `RST` input 1: synchronous, active-high reset.
- `cycle_idle`, `cycle_hit`, `cycle_miss`, `cycle_conflict`, `cycle_wait`, `num_miss` input 64 each: live counter values.
- `start` input 1: request one dump. Sampled only while idle.
- `clear` input 1: sampled with `start`. If 1, the counters are cleared after the snapshot.
- `reset_count` output 1: one-cycle clear pulse to the counter block.
- `busy` output 1: high from the cycle after `start` is accepted until the last word is accepted (inclusive).
- `out_data` output 32: stream word.
- `out_valid` output 1: stream valid.
- `out_last` output 1: high on word 12 only.
- `out_ready` input 1: stream ready from the consumer.

## Operation
- FSM states: IDLE, SEND.
- IDLE with `start`=1 at an edge:
  - Load six 64-bit shadow registers from the inputs.
  - Latch `clear` into `clr_pend`.
  - Set word index `idx`=0.
  - Go to SEND.
- In SEND, words in order:
  - idx 0: header = {HEADER_MAGIC, 8'd13, seq[15:0]}.
  - idx 1/2: idle lo/hi.
  - idx 3/4: hit lo/hi.
  - idx 5/6: miss lo/hi.
  - idx 7/8: conflict lo/hi.
  - idx 9/10: wait lo/hi.
  - idx 11/12: num_miss lo/hi.
- Transfer happens when `out_valid && out_ready`. On transfer, `idx` increments.
- On transfer of idx 12: return to IDLE and increment `seq` (16-bit, wraps FFFF→0000).
- The header of dump n (counted from reset) carries seq=n mod 65536.
- `reset_count` is 1 for exactly the first SEND cycle when `clr_pend`=1, and 0 otherwise. This is independent of `out_ready`. Counts occurring between the snapshot and the counter block's registered clear are deliberately discarded.
- `start` in SEND is ignored (no queueing). `clear` without `start` has no effect.
- Shadow registers hold their contents after a dump until the next accepted `start`. Live inputs never reach `out_data` directly.
- RST at any time:
  - State to IDLE, `idx`=0, `seq`=0, `clr_pend`=0, shadows=0.
  - Any partial dump is abandoned and `reset_count` is not issued.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, `reset_count`=0.
- `out_data`, `out_valid` and `out_last` are driven from registered state (`state`, `idx`, shadows). They are not combinational from `out_ready`.
- Latency: `start` accepted at edge k → `out_valid`=1 with the header from cycle k+1.
- Throughput: with `out_ready` held at 1, one word per cycle. Thirteen cycles per dump, cycles k+1..k+13.
- Stream rules:
  - Once `out_valid` rises, it stays high, with `out_data` and `out_last` stable, until the transfer.
  - `out_valid` never deasserts mid-dump except on RST.
- Back-to-back: the last word is accepted at edge m, so IDLE holds in cycle m+1. A `start` sampled at edge m+1 is accepted, and the next header appears in cycle m+2.
- A `start` in the same cycle as the idx-12 transfer is ignored.
- `busy` = (state==SEND).

## Structure
- Shared package `perfcounter_pkg`:
  - State enum (IDLE, SEND).
  - NUM_WORDS=13, WORD_W=32, CNT_W=64.
  - Counter index constants in transmit order (IDLE, HIT, MISS, CONFLICT, WAIT, NUM_MISS).
  - Default header magic.
- No sub-module required. A single module holds the FSM, the shadow bank and the 13-way word mux.

## Test plan
- Basic dump: inputs idle=64'h0000_0001_0000_0002, hit=5, miss=0, conflict=7, wait=64'hFFFF_FFFF_FFFF_FFFF, num_miss=3; `start`=1, `clear`=0; `out_ready`=1 → words A50D0000, 00000002, 00000001, 5, 0, 0, 0, 7, 0, FFFFFFFF, FFFFFFFF, 3, 0 on 13 consecutive cycles. `out_last` is high only on the 13th word. `reset_count` is never asserted.
- Snapshot consistency: change all inputs every cycle during SEND → transmitted values equal those present at the `start` edge.
- Backpressure: `out_ready` toggles 1,0,0,1,… → each word is held stable while ready is low. The word sequence is unchanged and no word is duplicated or dropped.
- Clear: `start`=1, `clear`=1 → `reset_count`=1 for exactly the cycle of the header's first valid, even with `out_ready`=0. The next dump's header seq is 0001.
- Ignored start / back-to-back: pulse `start` at word 5 → no effect. Pulse `start` in the cycle after the last transfer → a new header one cycle later.
- Reset mid-dump: assert RST at word 7 → next cycle all outputs are 0. The following dump's header is A50D0000 and no `reset_count` is issued.

Source files
------------

// File: rtl/perfcounter_pkg.sv
// Shared definitions for the performance-counter readout engine.
//   - FSM state encoding (IDLE, SEND)
//   - stream geometry: NUM_WORDS words of WORD_W bits, counters of CNT_W bits
//   - counter index constants in transmit order
//   - default header magic byte
package perfcounter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int NUM_WORDS = 13;
  localparam int WORD_W    = 32;
  localparam int CNT_W     = 64;
  localparam int NUM_CNT   = 6;
  localparam int IDX_W     = 4;
  localparam int SEQ_W     = 16;

  // Counter indices, in the order their lo/hi words follow the header.
  localparam int CNT_IDLE     = 0;
  localparam int CNT_HIT      = 1;
  localparam int CNT_MISS     = 2;
  localparam int CNT_CONFLICT = 3;
  localparam int CNT_WAIT     = 4;
  localparam int CNT_NUM_MISS = 5;

  localparam logic [7:0] HEADER_MAGIC_DEFAULT = 8'hA5;

endpackage

// File: rtl/perfcounter_reader.sv
// Readout engine for one performance-counter set.
// On an accepted start the six live 64-bit counters are snapshotted into a
// shadow bank in one cycle, then streamed as a header word followed by
// lo/hi halves of each counter over a valid/ready stream. If clear was
// requested with start, reset_count pulses in the first SEND cycle.
//
// Ports:
//   CLK, RST                   clock, synchronous active-high reset
//   cycle_idle .. num_miss     live 64-bit counter values
//   start, clear               dump request / clear-after-snapshot request
//   reset_count                one-cycle clear pulse to the counter block
//   busy                       high while a dump is in progress
//   out_data/out_valid/out_last/out_ready   32-bit output stream
module perfcounter_reader
  import perfcounter_pkg::*;
#(
  parameter logic [7:0] HEADER_MAGIC = HEADER_MAGIC_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [CNT_W-1:0]  cycle_idle,
  input  logic [CNT_W-1:0]  cycle_hit,
  input  logic [CNT_W-1:0]  cycle_miss,
  input  logic [CNT_W-1:0]  cycle_conflict,
  input  logic [CNT_W-1:0]  cycle_wait,
  input  logic [CNT_W-1:0]  num_miss,
  input  logic              start,
  input  logic              clear,
  output logic              reset_count,
  output logic              busy,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready
);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [SEQ_W-1:0]       seq_q, seq_d;
  logic                   clr_pend_q, clr_pend_d;
  logic                   load_shadow;
  logic [CNT_W-1:0]       shadow_q [NUM_CNT];
  logic [CNT_W-1:0]       live     [NUM_CNT];

  logic                   xfer;
  logic [IDX_W-1:0]       sel;
  logic [2:0]             cnt_sel;

  assign live[CNT_IDLE]     = cycle_idle;
  assign live[CNT_HIT]      = cycle_hit;
  assign live[CNT_MISS]     = cycle_miss;
  assign live[CNT_CONFLICT] = cycle_conflict;
  assign live[CNT_WAIT]     = cycle_wait;
  assign live[CNT_NUM_MISS] = num_miss;

  assign xfer = out_valid && out_ready;

  // Next-state logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    seq_d       = seq_q;
    clr_pend_d  = clr_pend_q;
    load_shadow = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SEND;
          idx_d       = '0;
          clr_pend_d  = clear;
          load_shadow = 1'b1;
        end
      end
      SEND: begin
        // The clear pulse lives only in the first SEND cycle.
        clr_pend_d = 1'b0;
        if (xfer) begin
          if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
            state_d = IDLE;
            idx_d   = '0;
            seq_d   = seq_q + 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      seq_q      <= '0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      seq_q      <= seq_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  // NOTE: the shadow bank is reset because its post-reset content is defined
  // as zero; storage with no defined reset value would be left unreset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_CNT; i++) shadow_q[i] <= '0;
    end else if (load_shadow) begin
      for (int i = 0; i < NUM_CNT; i++) shadow_q[i] <= live[i];
    end
  end

  // Outputs depend only on registered state, never on out_ready.
  assign busy        = (state_q == SEND);
  assign out_valid   = (state_q == SEND);
  assign out_last    = (state_q == SEND) && (idx_q == IDX_W'(NUM_WORDS - 1));
  assign reset_count = (state_q == SEND) && clr_pend_q;

  // Word idx>=1 maps to counter (idx-1)/2, low half on odd idx.
  assign sel     = idx_q - 1'b1;
  assign cnt_sel = sel[3:1];

  always_comb begin
    out_data = '0;
    if (state_q == SEND) begin
      if (idx_q == '0) begin
        out_data = {HEADER_MAGIC, 8'(NUM_WORDS), seq_q};
      end else if (cnt_sel < 3'(NUM_CNT)) begin
        out_data = sel[0] ? shadow_q[cnt_sel][CNT_W-1:WORD_W]
                          : shadow_q[cnt_sel][WORD_W-1:0];
      end
    end
  end

endmodule
